// File: rtl/filter_comb_decimator.sv
// Comb / decimator stage following filter_accumulator.
// Differences decimated integrator sums, scales them and saturates them to a signed sample.
module filter_comb_decimator #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 16,
    parameter int DECIM = 4,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [IN_W-1:0]  D,
    output logic [OUT_W-1:0] Q,
    output logic             valid,
    output logic             overflow
);

    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);

    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IN_W-1:0]  prev_q, prev_d;
    logic [OUT_W-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic                    tick;
    logic signed [IN_W-1:0]  diff;
    logic signed [IN_W-1:0]  scaled;
    logic [OUT_W-1:0]        sat_val;
    logic                    clamp;

    // Modular comb difference, gain shift and clamp to the output range
    always_comb begin
        diff    = $signed(D - prev_q);
        scaled  = diff >>> SHIFT;
        sat_val = scaled[OUT_W-1:0];
        clamp   = 1'b0;
        if (scaled > SAT_MAX) begin
            sat_val = OUT_MAX;
            clamp   = 1'b1;
        end else if (scaled < SAT_MIN) begin
            sat_val = OUT_MIN;
            clamp   = 1'b1;
        end
    end

    assign tick = enable && (cnt_q == CNT_LAST) && !load;

    // Next-state: load re-primes, tick either primes or emits a sample
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        q_d     = q_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        if (load) begin
            prev_d  = D;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = RUN;
        end else if (enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            if (tick) begin
                prev_d = D;
                if (state_q == PRIME) begin
                    state_d = RUN;
                end else begin
                    q_d     = sat_val;
                    valid_d = 1'b1;
                    if (clamp) begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRIME;
            cnt_q   <= '0;
            prev_q  <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Q        = q_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_filter_comb_decimator.sv
// Bench for filter_comb_decimator.
// Directed stimulus pushes expected samples; a negedge monitor pops and compares them.
module tb_filter_comb_decimator;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [19:0] D;
    logic [15:0] Q;
    logic        valid;
    logic        overflow;

    typedef struct {
        logic [15:0] q;
        logic        ovf;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    int   edges;

    filter_comb_decimator #(
        .IN_W(20), .OUT_W(16), .DECIM(4), .SHIFT(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .D(D), .Q(Q), .valid(valid), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        edges = 0;
        forever begin
            @(posedge clk);
            edges++;
        end
    end

    // Monitor: every valid strobe must match the oldest expected sample
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid: edge %0d Q=%h, required no valid",
                             edges, Q);
                end else begin
                    e = exp_q.pop_front();
                    if (Q !== e.q || overflow !== e.ovf || edges != e.at) begin
                        fails++;
                        $display("FAIL sample: got Q=%h ovf=%b edge %0d, required Q=%h ovf=%b edge %0d",
                                 Q, overflow, edges, e.q, e.ovf, e.at);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One clock with given inputs; optionally expect a sample from this edge
    task automatic step(input logic en, input logic ld, input logic [19:0] d,
                        input logic ex, input logic [15:0] eq,
                        input logic eo);
        exp_t e;
        enable = en;
        load   = ld;
        D      = d;
        @(posedge clk);
        #1;
        if (ex) begin
            e.q   = eq;
            e.ovf = eo;
            e.at  = edges;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset(input logic en, input logic ld);
        rst    = 1'b1;
        enable = en;
        load   = ld;
        D      = 20'h12345;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        D      = '0;
        @(posedge clk);
        #1;

        // reset dominates load and enable
        do_reset(1'b1, 1'b1);
        check("reset_q", 32'(Q), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_ovf", 32'(overflow), 32'h0);

        // ramp +0x10 per cycle: one sample of 0x10 every 4th cycle
        step(1, 1, 20'h00000, 0, 16'h0, 0);
        for (int k = 1; k <= 12; k++) begin
            step(1, 0, 20'(k * 16), (k % 4) == 0, 16'h0010, 0);
        end

        // wrap of D through zero
        step(0, 1, 20'hFFFF0, 0, 16'h0, 0);
        step(1, 0, 20'hAAAAA, 0, 16'h0, 0);
        step(1, 0, 20'h55555, 0, 16'h0, 0);
        step(1, 0, 20'h00000, 0, 16'h0, 0);
        step(1, 0, 20'h00030, 1, 16'h0010, 0);

        // positive clamp, sticky flag
        step(0, 1, 20'h00000, 0, 16'h0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 20'h11111, 0, 16'h0, 0);
        step(1, 0, 20'h40000, 1, 16'h7FFF, 1);
        step(0, 0, 20'h00000, 0, 16'h0, 0);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // load clears flag, negative clamp re-sets it
        step(0, 1, 20'h00000, 0, 16'h0, 0);
        check("ovf_load_clear", 32'(overflow), 32'h0);
        for (int k = 0; k < 3; k++) step(1, 0, 20'h22222, 0, 16'h0, 0);
        step(1, 0, 20'hC0000, 1, 16'h8000, 1);

        // freeze at counter=2 for 10 cycles
        step(0, 1, 20'h00100, 0, 16'h0, 0);
        step(1, 0, 20'h00110, 0, 16'h0, 0);
        step(1, 0, 20'h00120, 0, 16'h0, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 20'h55555, 0, 16'h0, 0);
        check("freeze_q_held", 32'(Q), 32'h8000);
        check("freeze_ovf", 32'(overflow), 32'h0);
        step(1, 0, 20'h00130, 0, 16'h0, 0);
        step(1, 0, 20'h00140, 1, 16'h0010, 0);

        // load on a tick cycle suppresses the sample and re-primes
        step(0, 1, 20'h00000, 0, 16'h0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 20'h00040, 0, 16'h0, 0);
        step(1, 1, 20'h00200, 0, 16'h0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 20'h33333, 0, 16'h0, 0);
        step(1, 0, 20'h00180, 1, 16'hFFE0, 0);

        // reset mid-count with load and enable: back to PRIME
        step(1, 0, 20'h00190, 0, 16'h0, 0);
        do_reset(1'b1, 1'b1);
        check("rst2_q", 32'(Q), 32'h0);
        check("rst2_valid", 32'(valid), 32'h0);
        check("rst2_ovf", 32'(overflow), 32'h0);
        for (int k = 1; k <= 3; k++) step(1, 0, 20'h77777, 0, 16'h0, 0);
        step(1, 0, 20'h01000, 0, 16'h0, 0);
        for (int k = 1; k <= 3; k++) step(1, 0, 20'h66666, 0, 16'h0, 0);
        step(1, 0, 20'h01060, 1, 16'h0018, 0);

        for (int k = 0; k < 4; k++) step(0, 0, 20'h0, 0, 16'h0, 0);
        check("all_samples_seen", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter_comb_decimator.md
Name: filter_comb_decimator

Overview:
- Read-side partner of filter_accumulator: consumes the running 20-bit integrator sum Q and recovers band-limited 16-bit samples.
- Decimates by DECIM, differences consecutive decimated sums (comb stage, modulo 2^IN_W), right-shifts by SHIFT, and saturates to OUT_W.
- Sits directly after filter_accumulator in the filter chain. Outputs a one-cycle valid strobe per decimated sample.

Parameters:
- IN_W, 20, width of accumulator sum input D
- OUT_W, 16, width of signed output sample Q
- DECIM, 4, decimation ratio (>=2); one output per DECIM enabled cycles
- SHIFT, 2, arithmetic right shift applied to difference (gain normalisation)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- enable  in  1  advances decimation counter; low = freeze all state except rst/load
- load  in  1  re-prime: prev <= D, counter <= 0, state <= RUN, overflow <= 0
- D  in  IN_W  accumulator sum (two's complement, wraps)
- Q  out  OUT_W  signed decimated sample, held between valid strobes
- valid  out  1  one-cycle pulse when Q updates
- overflow  out  1  sticky saturation flag

Behaviour:
- Reset: one clock, synchronous, active-high. Q=0, valid=0, overflow=0, prev=0, counter=0, state=PRIME. rst beats load/enable. rst mid-operation discards any pending sample.
- States:
  - PRIME: no reference sum is held yet.
  - RUN: normal differencing.
- Counter runs 0..DECIM-1 on enabled cycles and wraps to 0. tick = enable && counter==DECIM-1 && !load.
- load (any enable value): prev<=D, counter<=0, overflow<=0, state<=RUN, valid<=0, Q held. load beats tick on the same cycle.
- tick in PRIME: prev<=D, state<=RUN, no valid.
- tick in RUN:
  - diff = (D - prev) mod 2^IN_W, interpreted as signed IN_W.
  - prev<=D.
  - s = diff >>> SHIFT (sign-extending).
  - Q <= sat(s): clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - valid<=1 on the next cycle. Latency: D sampled on tick edge; Q/valid visible one cycle later.
- Wrap-around of D, and of D - prev, is legal and yields the correct modular difference. No saturation is applied on the subtraction itself.
- overflow set on any clamp; cleared only by rst or load.
- valid is never high on two consecutive cycles (DECIM>=2).
- enable low: counter, prev, state frozen; valid=0; Q holds.
- First valid after reset without load: requires 2*DECIM enabled cycles (one prime tick, one run tick). After load: DECIM enabled cycles.

Test Plan:
- Ramp: rst; load=1 with D=0x00000; then enable=1, D stepping +0x10 per cycle. Required: valid every 4th cycle, Q=0x0010 each time, overflow=0.
- Wrap: load with D=0xFFFF0; at next tick D=0x00030. Required: diff=0x00040, Q=0x0010, overflow=0.
- Saturation: load D=0x00000, tick D=0x40000 -> Q=0x7FFF, overflow=1. Then load D=0x00000, tick D=0xC0000 -> Q=0x8000, overflow=1 (load cleared it, clamp re-set it).
- Freeze: drop enable for 10 cycles mid-count (counter=2). Required: no valid, Q held; after re-enable the tick occurs 2 enabled cycles later.
- Priority: assert load on a tick cycle -> no valid, counter=0, prev=D. Assert rst with load and enable -> Q=0, valid=0, state=PRIME, and the first valid arrives 8 enabled cycles after rst deasserts.
